// File: rtl/freq_meter_mc.sv
// Multi-channel equal-precision frequency meter: per-channel gate opens and closes on input edges.
// Optional macro FREQ_MEAS_CONT_EN: re-arm automatically after O_done while I_start stays high.
module freq_meter_mc #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int GATE_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      I_sys_clk,
    input  logic                      I_rst,
    input  logic                      I_start,
    input  logic [NUM_CH-1:0]         I_ch_en,
    input  logic [NUM_CH-1:0]         I_sig_fx,
    output logic                      O_busy,
    output logic                      O_done,
    output logic [NUM_CH-1:0]         O_valid,
    output logic [NUM_CH-1:0]         O_timeout,
    output logic [NUM_CH-1:0]         O_ovf,
    output logic [NUM_CH*CNT_W-1:0]   O_fx_cnt,
    output logic [NUM_CH*CNT_W-1:0]   O_f0_cnt
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] GATE_C = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMO_T  = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, FIN} st_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic start_q, start_prev_q, busy_q, done_q;
    logic accept, rearm, done_evt;
    logic [NUM_CH-1:0] fin;
    logic [NUM_CH-1:0][CNT_W-1:0] fx_w, f0_w, fx_res_q, f0_res_q;
    logic [NUM_CH-1:0] vld_w, to_w, ovf_w, vld_res_q, to_res_q, ovf_res_q;

`ifdef FREQ_MEAS_CONT_EN
    assign rearm = done_q & start_q;
`else
    assign rearm = 1'b0;
`endif

    assign accept   = ~busy_q & ((start_q & ~start_prev_q) | rearm);
    assign done_evt = busy_q & (&fin);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q, edge_w;
        st_e                    st_q;
        logic [TMR_W-1:0]       tmr_q, tmr_inc;
        logic [CNT_W-1:0]       fx_q, f0_q, fx_inc, f0_inc;
        logic                   vld_q, to_q, ovf_q;

        assign edge_w  = sync_q[SYNC_STAGES-1] & ~prev_q;
        assign fx_inc  = sat_inc(fx_q);
        assign f0_inc  = sat_inc(f0_q);
        assign tmr_inc = tmr_q + TMR_W'(1);

        always_ff @(posedge I_sys_clk or posedge I_rst) begin
            if (I_rst) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], I_sig_fx[k]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        always_ff @(posedge I_sys_clk or posedge I_rst) begin
            if (I_rst) begin
                st_q  <= IDLE;
                tmr_q <= '0;
                fx_q  <= '0;
                f0_q  <= '0;
                vld_q <= 1'b0;
                to_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                case (st_q)
                    IDLE: if (accept) begin
                        tmr_q <= '0;
                        fx_q  <= '0;
                        f0_q  <= '0;
                        vld_q <= 1'b0;
                        to_q  <= 1'b0;
                        ovf_q <= 1'b0;
                        st_q  <= I_ch_en[k] ? ARM : FIN;
                    end
                    ARM: begin
                        tmr_q <= tmr_inc;
                        if (edge_w) begin
                            fx_q <= '0;
                            f0_q <= '0;
                            st_q <= MEAS;
                        end else if (tmr_inc == TMO_T) begin
                            to_q <= 1'b1;
                            st_q <= FIN;
                        end
                    end
                    MEAS: begin
                        f0_q <= f0_inc;
                        if (edge_w) fx_q <= fx_inc;
                        if ((&f0_inc) || (edge_w && (&fx_inc))) ovf_q <= 1'b1;
                        // An edge always wins over a coincident timeout.
                        if (edge_w && f0_inc >= GATE_C) begin
                            vld_q <= 1'b1;
                            st_q  <= FIN;
                        end else if (!edge_w && (f0_inc >= TMO_C || (&f0_inc))) begin
                            to_q <= 1'b1;
                            st_q <= FIN;
                        end
                    end
                    default: if (done_evt) st_q <= IDLE;
                endcase
            end
        end

        assign fin[k]   = (st_q == FIN);
        assign fx_w[k]  = fx_q;
        assign f0_w[k]  = f0_q;
        assign vld_w[k] = vld_q;
        assign to_w[k]  = to_q;
        assign ovf_w[k] = ovf_q;
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fx_res_q     <= '0;
            f0_res_q     <= '0;
            vld_res_q    <= '0;
            to_res_q     <= '0;
            ovf_res_q    <= '0;
        end else begin
            start_q      <= I_start;
            start_prev_q <= start_q;
            done_q       <= done_evt;
            if (accept)        busy_q <= 1'b1;
            else if (done_evt) busy_q <= 1'b0;
            if (done_evt) begin
                fx_res_q  <= fx_w;
                f0_res_q  <= f0_w;
                vld_res_q <= vld_w;
                to_res_q  <= to_w;
                ovf_res_q <= ovf_w;
            end
        end
    end

    assign O_busy    = busy_q;
    assign O_done    = done_q;
    assign O_valid   = vld_res_q;
    assign O_timeout = to_res_q;
    assign O_ovf     = ovf_res_q;
    assign O_fx_cnt  = fx_res_q;
    assign O_f0_cnt  = f0_res_q;

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed bench for freq_meter_mc with a short gate (1000) and timeout (4000).
module tb_freq_meter_mc;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   ch_en = '0;
    logic [3:0]   sig = '0;
    logic         busy, done;
    logic [3:0]   valid, tmo, ovf;
    logic [127:0] fx_cnt, f0_cnt;
    int checks = 0;
    int errors = 0;
    int per[4] = '{0, 0, 0, 0};
    int ph[4]  = '{0, 0, 0, 0};

    freq_meter_mc #(
        .NUM_CH(4), .CNT_W(32), .GATE_CYCLES(1000), .TIMEOUT_CYCLES(4000), .SYNC_STAGES(2)
    ) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_start(start), .I_ch_en(ch_en), .I_sig_fx(sig),
        .O_busy(busy), .O_done(done), .O_valid(valid), .O_timeout(tmo), .O_ovf(ovf),
        .O_fx_cnt(fx_cnt), .O_f0_cnt(f0_cnt)
    );

    always #5 clk = ~clk;

    // Square-wave sources: period per[k] sys cycles, 0 holds the input low.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (per[k] == 0) begin
                sig[k] = 1'b0;
                ph[k]  = 0;
            end else begin
                ph[k]  = (ph[k] + 1) % per[k];
                sig[k] = (ph[k] < per[k] / 2);
            end
        end
    end

    function automatic logic [31:0] fxc(input int k);
        return fx_cnt[k*32 +: 32];
    endfunction

    function automatic logic [31:0] f0c(input int k);
        return f0_cnt[k*32 +: 32];
    endfunction

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (cyc < maxc) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, valid, tmo, ovf} !== 14'd0) begin
            errors++; $display("FAIL reset_flags: got %b exp 0", {busy, done, valid, tmo, ovf});
        end
        checks++;
        if (fx_cnt !== '0 || f0_cnt !== '0) begin
            errors++; $display("FAIL reset_counts: fx %h f0 %h exp 0", fx_cnt, f0_cnt);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single(input int k, input int p, input int efx, input int ef0);
        int cyc;
        per = '{default: 0};
        per[k] = p;
        ch_en = 4'(1 << k);
        repeat (20) @(negedge clk);
        start_pulse();
        wait_done(3000, cyc);
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL single%0d_done: no O_done within 3000 cycles", k); end
        checks++;
        if (fxc(k) !== 32'(efx)) begin errors++; $display("FAIL single%0d_fx: got %0d exp %0d", k, fxc(k), efx); end
        checks++;
        if (f0c(k) !== 32'(ef0)) begin errors++; $display("FAIL single%0d_f0: got %0d exp %0d", k, f0c(k), ef0); end
        checks++;
        if (valid !== 4'(1 << k) || tmo !== 4'd0 || ovf !== 4'd0) begin
            errors++; $display("FAIL single%0d_flags: valid %b tmo %b ovf %b exp valid %b", k, valid, tmo, ovf, 4'(1 << k));
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single%0d_pulse: done %b busy %b exp 0 0", k, done, busy);
        end
        per[k] = 0;
    endtask

    task automatic test_timeout();
        int cyc;
        per = '{default: 0};
        ch_en = 4'b0100;
        repeat (5) @(negedge clk);
        start_pulse();
        wait_done(5000, cyc);
        checks++;
        if (cyc < 3995 || cyc > 4010) begin errors++; $display("FAIL timeout_latency: got %0d exp ~4001", cyc); end
        checks++;
        if (tmo !== 4'b0100 || valid !== 4'b0000) begin
            errors++; $display("FAIL timeout_flags: tmo %b valid %b exp 0100 0000", tmo, valid);
        end
        checks++;
        if (fx_cnt !== '0 || f0_cnt !== '0) begin
            errors++; $display("FAIL timeout_counts: fx %h f0 %h exp 0", fx_cnt, f0_cnt);
        end
    endtask

    task automatic test_multi();
        int cyc;
        per = '{10, 0, 25, 0};
        ch_en = 4'b0101;
        repeat (20) @(negedge clk);
        start_pulse();
        wait_done(3000, cyc);
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL multi_done: no O_done within 3000 cycles"); end
        checks++;
        if (valid !== 4'b0101 || tmo !== 4'b0000) begin
            errors++; $display("FAIL multi_flags: valid %b tmo %b exp 0101 0000", valid, tmo);
        end
        checks++;
        if (fxc(0) !== 32'd100 || f0c(0) !== 32'd1000) begin
            errors++; $display("FAIL multi_ch0: fx %0d f0 %0d exp 100 1000", fxc(0), f0c(0));
        end
        checks++;
        if (fxc(2) !== 32'd40 || f0c(2) !== 32'd1000) begin
            errors++; $display("FAIL multi_ch2: fx %0d f0 %0d exp 40 1000", fxc(2), f0c(2));
        end
        checks++;
        if (f0c(0) !== fxc(0) * 10 || f0c(2) !== fxc(2) * 25) begin
            errors++; $display("FAIL multi_invariant: ch0 %0d/%0d ch2 %0d/%0d", fxc(0), f0c(0), fxc(2), f0c(2));
        end
        checks++;
        if (fxc(1) !== 0 || f0c(1) !== 0 || fxc(3) !== 0 || f0c(3) !== 0) begin
            errors++; $display("FAIL multi_idle_ch: ch1 %0d/%0d ch3 %0d/%0d exp 0", fxc(1), f0c(1), fxc(3), f0c(3));
        end
        per = '{default: 0};
    endtask

    task automatic test_restart_reset();
        int cyc;
        per = '{10, 0, 0, 0};
        ch_en = 4'b0001;
        repeat (20) @(negedge clk);
        start_pulse();
        repeat (300) @(negedge clk);
        start_pulse();
        wait_done(3000, cyc);
        checks++;
        if (cyc <= 0 || cyc >= 800) begin errors++; $display("FAIL restart_ignored: done after %0d cycles exp <800", cyc); end
        checks++;
        if (fxc(0) !== 32'd100 || f0c(0) !== 32'd1000) begin
            errors++; $display("FAIL restart_counts: fx %0d f0 %0d exp 100 1000", fxc(0), f0c(0));
        end
        start_pulse();
        repeat (200) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, valid, tmo, ovf} !== 14'd0 || fx_cnt !== '0 || f0_cnt !== '0) begin
            errors++; $display("FAIL midreset: flags %b fx %h f0 %h exp 0", {busy, done, valid, tmo, ovf}, fx_cnt, f0_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        per[0] = 0;
        test_single(0, 10, 100, 1000);
    endtask

`ifdef FREQ_MEAS_CONT_EN
    task automatic test_continuous();
        int cyc;
        int ndone;
        per = '{10, 0, 0, 0};
        ch_en = 4'b0001;
        repeat (20) @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(3000, cyc);
            checks++;
            if (cyc < 0 || (i > 0 && (cyc < 1001 || cyc > 1030))) begin
                errors++; $display("FAIL cont_interval%0d: got %0d exp 1001..1030", i, cyc);
            end
            checks++;
            if (fxc(0) !== 32'd100 || f0c(0) !== 32'd1000) begin
                errors++; $display("FAIL cont_counts%0d: fx %0d f0 %0d exp 100 1000", i, fxc(0), f0c(0));
            end
        end
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done(3000, cyc);
            if (cyc > 0) ndone++;
        end
        checks++;
        if (ndone != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL cont_stop: %0d extra dones busy %b exp 1 0", ndone, busy);
        end
        per[0] = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single(0, 10, 100, 1000);
        test_single(1, 7, 143, 1001);
        test_timeout();
        test_multi();
        test_restart_reset();
`ifdef FREQ_MEAS_CONT_EN
        test_continuous();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
